mod_counter_updn: RTL and testbench

// - Parametrised up/down modulo counter; next generation of the 8-bit ripple-enable counter.
// - Adds programmable width, runtime modulus (limit), count direction, synchronous clear and parallel load.
// - Adds wrap or saturate mode, a terminal-count flag and a registered wrap pulse.
// - Used for timing, sample-index and address sequencing in the datapath; one instance per channel.

---
 rtl/counter_pkg.sv | 41 ++++
 rtl/mod_counter_next.sv | 39 +++
 rtl/mod_counter_updn.sv | 76 +++++++
 tb/tb_mod_counter_updn.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down modulo counter family.
package counter_pkg;

    // Default count register width for a fresh instance.
    localparam int unsigned CNT_WIDTH_DEF = 8;

    // Behaviour at the terminal value.
    localparam int unsigned SAT_MODE_WRAP = 0;
    localparam int unsigned SAT_MODE_SAT  = 1;

    // Per-edge action chosen by the priority mux.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_CLEAR = 2'd1,
        OP_LOAD  = 2'd2,
        OP_STEP  = 2'd3
    } cnt_op_e;

    // Control strobes sampled on every rising edge.
    typedef struct packed {
        logic clr;
        logic load;
        logic en;
        logic up;
    } cnt_ctrl_t;

    // Resolve control strobes to a single action: clear beats load beats count.
    function automatic cnt_op_e cnt_op_sel(input cnt_ctrl_t ctrl);
        cnt_op_e op;
        op = OP_HOLD;
        if (ctrl.clr) begin
            op = OP_CLEAR;
        end else if (ctrl.load) begin
            op = OP_LOAD;
        end else if (ctrl.en) begin
            op = OP_STEP;
        end
        return op;
    endfunction

endpackage : counter_pkg

// File: rtl/mod_counter_next.sv
// Combinational step logic: value after one enabled count and terminal detect.
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = CNT_WIDTH_DEF,
    parameter int unsigned SAT_MODE = SAT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             up_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] q_next_c_o,
    output logic             term_c_o
);

    localparam bit SAT = (SAT_MODE == SAT_MODE_SAT);

    // Up-count terminates at or above limit so a load past limit still wraps;
    // down-count terminates at zero and reloads limit.
    always_comb begin
        q_next_c_o = q_i;
        term_c_o   = 1'b0;
        if (up_i) begin
            term_c_o = (q_i >= limit_i);
            if (!term_c_o) begin
                q_next_c_o = q_i + WIDTH'(1);
            end else if (!SAT) begin
                q_next_c_o = '0;
            end
        end else begin
            term_c_o = (q_i == '0);
            if (!term_c_o) begin
                q_next_c_o = q_i - WIDTH'(1);
            end else if (!SAT) begin
                q_next_c_o = limit_i;
            end
        end
    end

endmodule : mod_counter_next

// File: rtl/mod_counter_updn.sv
// Parametrised up/down modulo counter with clear, load, wrap/saturate and wrap pulse.
module mod_counter_updn
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = CNT_WIDTH_DEF,
    parameter int unsigned SAT_MODE = SAT_MODE_WRAP
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] step_val;
    logic             term;
    cnt_ctrl_t        ctrl;
    cnt_op_e          op;

    assign ctrl = '{clr: clr, load: load, en: en, up: up};
    assign op   = cnt_op_sel(ctrl);

    // Next value and terminal detect for an enabled step from the current count.
    mod_counter_next #(
        .WIDTH    (WIDTH),
        .SAT_MODE (SAT_MODE)
    ) u_next (
        .q_i        (q_q),
        .up_i       (up),
        .limit_i    (limit),
        .q_next_c_o (step_val),
        .term_c_o   (term)
    );

    // Priority mux; wrap only reports a terminal step, never a clear or load.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        case (op)
            OP_CLEAR: q_d = '0;
            OP_LOAD:  q_d = load_val;
            OP_STEP: begin
                q_d    = step_val;
                wrap_d = term;
            end
            default: q_d = q_q;
        endcase
    end

    // Count and wrap-pulse registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // Terminal flag is same-cycle and gated only by en.
    assign tc   = en & term;
    assign q    = q_q;
    assign wrap = wrap_q;

endmodule : mod_counter_updn

// File: tb/tb_mod_counter_updn.sv
// Bench for mod_counter_updn: a wrap-mode and a saturate-mode instance share stimulus.
module tb_mod_counter_updn;
    import counter_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         resetb;
    logic         en;
    logic         up;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] limit;
    logic [W-1:0] q_w;
    logic [W-1:0] q_s;
    logic         tc_w;
    logic         tc_s;
    logic         wrap_w;
    logic         wrap_s;

    always #5 clk = ~clk;

    mod_counter_updn #(.WIDTH(W), .SAT_MODE(SAT_MODE_WRAP)) dut_w (
        .clk(clk), .resetb(resetb), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .limit(limit), .q(q_w), .tc(tc_w), .wrap(wrap_w)
    );

    mod_counter_updn #(.WIDTH(W), .SAT_MODE(SAT_MODE_SAT)) dut_s (
        .clk(clk), .resetb(resetb), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .limit(limit), .q(q_s), .tc(tc_s), .wrap(wrap_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: index 0 = wrap mode, index 1 = saturate mode.
    int mq[2];
    int mw[2];

    typedef struct {
        bit clr;
        bit load;
        bit en;
        bit up;
        int load_val;
        int limit;
        int q0;
        int q1;
        int w0;
        int w1;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mkvec(bit c, bit l, bit e, bit u, int lv, int lim,
                                   int q0, int q1, int w0, int w1);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.up = u;
        v.load_val = lv; v.limit = lim;
        v.q0 = q0; v.q1 = q1; v.w0 = w0; v.w1 = w1;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit c, input bit l, input bit e, input bit u,
                          input int lv, input int lim);
        clr      = c;
        load     = l;
        en       = e;
        up       = u;
        load_val = W'(lv);
        limit    = W'(lim);
    endtask

    // Expected terminal flag from the current model count and inputs.
    function automatic int model_tc(input int m);
        if (!en) return 0;
        if (up) return (mq[m] >= int'(limit)) ? 1 : 0;
        return (mq[m] == 0) ? 1 : 0;
    endfunction

    // Reference behaviour in plain integer arithmetic, one clock edge.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (clr) begin
                mq[m] = 0;
                mw[m] = 0;
            end else if (load) begin
                mq[m] = int'(load_val);
                mw[m] = 0;
            end else if (en && up) begin
                if (mq[m] >= int'(limit)) begin
                    mw[m] = 1;
                    if (m == 0) mq[m] = 0;
                end else begin
                    mw[m] = 0;
                    mq[m] = mq[m] + 1;
                end
            end else if (en) begin
                if (mq[m] == 0) begin
                    mw[m] = 1;
                    if (m == 0) mq[m] = int'(limit);
                end else begin
                    mw[m] = 0;
                    mq[m] = mq[m] - 1;
                end
            end else begin
                mw[m] = 0;
            end
        end
    endtask

    // Advance one edge; returns 1 ns after the rising edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_q_wrapmode"},    int'(q_w),    mq[0]);
        check({tag, "_wrap_wrapmode"}, int'(wrap_w), mw[0]);
        check({tag, "_q_satmode"},     int'(q_s),    mq[1]);
        check({tag, "_wrap_satmode"},  int'(wrap_s), mw[1]);
    endtask

    initial begin
        int nwrap;
        int r;

        vecs[0]  = mkvec(0, 1, 1, 1, 200, 9, 200, 200, 0, 0);
        vecs[1]  = mkvec(0, 0, 1, 1,   0, 9,   0, 200, 1, 1);
        vecs[2]  = mkvec(1, 1, 1, 1,  77, 9,   0,   0, 0, 0);
        vecs[3]  = mkvec(0, 0, 1, 1,   0, 9,   1,   1, 0, 0);
        vecs[4]  = mkvec(0, 0, 1, 0,   0, 9,   0,   0, 0, 0);
        vecs[5]  = mkvec(0, 0, 1, 0,   0, 9,   9,   0, 1, 1);
        vecs[6]  = mkvec(0, 0, 0, 1,   0, 9,   9,   0, 0, 0);
        vecs[7]  = mkvec(0, 1, 0, 0,   3, 9,   3,   3, 0, 0);
        vecs[8]  = mkvec(0, 0, 1, 1,   0, 0,   0,   3, 1, 1);
        vecs[9]  = mkvec(0, 0, 1, 1,   0, 0,   0,   3, 1, 1);
        vecs[10] = mkvec(0, 0, 1, 0,   0, 5,   5,   2, 1, 0);
        vecs[11] = mkvec(0, 0, 1, 0,   0, 5,   4,   1, 0, 0);
        vecs[12] = mkvec(1, 0, 0, 0,   0, 5,   0,   0, 0, 0);

        // Reset state
        resetb = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        mq[0] = 0; mq[1] = 0; mw[0] = 0; mw[1] = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_q_wrapmode",    int'(q_w),    0);
        check("reset_wrap_wrapmode", int'(wrap_w), 0);
        check("reset_q_satmode",     int'(q_s),    0);
        resetb = 1'b1;

        // Table vectors, applied back to back from q=0
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up,
                   vecs[i].load_val, vecs[i].limit);
            cycle();
            check($sformatf("vec%0d_q_wrapmode", i),    int'(q_w),    vecs[i].q0);
            check($sformatf("vec%0d_q_satmode", i),     int'(q_s),    vecs[i].q1);
            check($sformatf("vec%0d_wrap_wrapmode", i), int'(wrap_w), vecs[i].w0);
            check($sformatf("vec%0d_wrap_satmode", i),  int'(wrap_s), vecs[i].w1);
        end

        // Up-wrap 0..9 with limit 9
        set_in(1, 0, 0, 1, 0, 9);
        cycle();
        set_in(0, 0, 1, 1, 0, 9);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("upwrap_q%0d", i), int'(q_w), i);
            check($sformatf("upwrap_tc%0d", i), int'(tc_w), (i == 9) ? 1 : 0);
            cycle();
        end
        check("upwrap_q_after",       int'(q_w),    0);
        check("upwrap_wrap_after",    int'(wrap_w), 1);
        check("upwrap_sat_q_hold",    int'(q_s),    9);
        check("upwrap_sat_wrap",      int'(wrap_s), 1);

        // Down-wrap from 1 with limit 9
        set_in(0, 1, 0, 0, 1, 9);
        cycle();
        set_in(0, 0, 1, 0, 0, 9);
        #1;
        check("down_tc_at1", int'(tc_w), 0);
        cycle();
        #1;
        check("down_q0_wrapmode", int'(q_w),  0);
        check("down_q0_satmode",  int'(q_s),  0);
        check("down_tc0_wrapmode", int'(tc_w), 1);
        check("down_tc0_satmode",  int'(tc_s), 1);
        cycle();
        check("down_reload_q",    int'(q_w),    9);
        check("down_reload_wrap", int'(wrap_w), 1);
        check("down_sat_q",       int'(q_s),    0);
        check("down_sat_wrap",    int'(wrap_s), 1);

        // Saturate up at limit 255
        set_in(0, 1, 0, 1, 250, 255);
        cycle();
        set_in(0, 0, 1, 1, 0, 255);
        for (int i = 0; i < 5; i++) cycle();
        check("sat_reach_255", int'(q_s), 255);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("sat_tc%0d", i), int'(tc_s), 1);
            cycle();
            check($sformatf("sat_hold%0d", i), int'(q_s),    255);
            check($sformatf("sat_wrap%0d", i), int'(wrap_s), 1);
        end

        // Legacy free-running modulo-256
        set_in(1, 0, 0, 1, 0, 255);
        cycle();
        set_in(0, 0, 1, 1, 0, 255);
        nwrap = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (wrap_w) nwrap++;
        end
        check("legacy_q_return", int'(q_w), 0);
        check("legacy_wrap_count", nwrap, 1);

        // Asynchronous reset mid-count at q=5
        set_in(1, 0, 0, 1, 0, 9);
        cycle();
        set_in(0, 0, 1, 1, 0, 9);
        for (int i = 0; i < 5; i++) cycle();
        check("areset_pre_q", int'(q_w), 5);
        #2;
        resetb = 1'b0;
        #1;
        check("areset_q_wrapmode",    int'(q_w),    0);
        check("areset_wrap_wrapmode", int'(wrap_w), 0);
        check("areset_q_satmode",     int'(q_s),    0);
        mq[0] = 0; mq[1] = 0; mw[0] = 0; mw[1] = 0;
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 1, 0, 9);
        resetb = 1'b1;
        cycle();
        check_model("post_reset");

        // Randomised stimulus against the reference model
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 3));
            set_in($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                   $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 255)),
                   (r == 0) ? 0 : (r == 1) ? 255 : (r == 2) ? int'($urandom_range(0, 15))
                                                            : int'($urandom_range(0, 255)));
            #1;
            check("rand_tc_wrapmode", int'(tc_w), model_tc(0));
            check("rand_tc_satmode",  int'(tc_s), model_tc(1));
            cycle();
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mod_counter_updn
